rom_ctrl: RTL and testbench

Controller in front of the single-port instruction ROM (`RomNum words, word-addressed by addr[31:2], combinational read, synchronous write). It shares the ROM between three requesters: the program loader (writes), the core data bus (reads) and the core instruction fetch (reads). It also sequences a program-download session: halt the core, accept writes, then release the core through a timed reset pulse.

---
 rtl/rom_ctrl_pkg.sv | 25 ++
 rtl/rom_ctrl_rd_arb.sv | 28 ++
 rtl/rom_ctrl.sv | 154 +++++++++++++++
 tb/tb_rom_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_ctrl_pkg.sv
// Shared constants, FSM encodings and address helpers for the instruction-ROM controller.
// Every file that needs these imports them with import rom_ctrl_pkg::*.
package rom_ctrl_pkg;

  localparam int unsigned ROM_NUM      = 4096;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic        RST_ENABLE   = 1'b1;

  // Controller FSM encodings.
  localparam logic [1:0] RC_RUN  = 2'd0;
  localparam logic [1:0] RC_LOAD = 2'd1;
  localparam logic [1:0] RC_REL  = 2'd2;

  // Returns 1 when the word index addr[31:2] falls inside a ROM of 'words' entries.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned words);
    return {2'b00, addr[31:2]} < words;
  endfunction

  // Clears the byte-lane bits so the ROM only ever sees word addresses.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rom_ctrl_rd_arb.sv
// Combinational read arbiter: the data bus has priority, except that a fetch denied in the
// previous cycle wins, so fetch is never starved for more than one cycle.
module rom_rd_arb (
  input  logic en_i,
  input  logic d_req_i,
  input  logic i_req_i,
  input  logic starve_i,
  output logic d_gnt_o,
  output logic i_gnt_o,
  output logic hold_o
);

  always_comb begin
    // NOTE: every output gets a default first, so no path through the block can infer a latch.
    d_gnt_o = 1'b0;
    i_gnt_o = 1'b0;
    hold_o  = 1'b0;
    if (en_i) begin
      hold_o = d_req_i & i_req_i;
      if (i_req_i && (starve_i || !d_req_i)) begin
        i_gnt_o = 1'b1;
      end else if (d_req_i) begin
        d_gnt_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_ctrl.sv
// Shares the single-port instruction ROM between loader writes, data-bus reads and fetch reads,
// and sequences a download session: RUN -> LOAD -> RELEASE (timed core reset) -> RUN.
module rom_ctrl
  import rom_ctrl_pkg::*;
#(
  parameter int unsigned ROM_WORDS  = ROM_NUM,
  parameter int unsigned REL_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_start_i,
  input  logic        ld_done_i,
  input  logic        ld_req_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i,
  output logic        ld_ack_o,
  output logic        ld_err_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  output logic        d_valid_o,
  output logic [31:0] d_rdata_o,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_valid_o,
  output logic [31:0] i_rdata_o,
  output logic        rom_we_o,
  output logic [31:0] rom_addr_o,
  output logic [31:0] rom_data_o,
  input  logic [31:0] rom_data_i,
  output logic        hold_o,
  output logic        cpu_rst_o,
  output logic [15:0] word_cnt_o
);

  logic [1:0]  state_q, state_d;
  logic [7:0]  rel_cnt_q, rel_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        starve_q;
  logic        d_valid_q, i_valid_q, ld_ack_q, ld_err_q;
  logic [31:0] d_rdata_q, i_rdata_q;

  logic in_rst, run_en, load_en;
  logic d_gnt, i_gnt, arb_hold;
  logic d_ok, i_ok, ld_ok, wr_ok, wr_bad;

  // Reset gates the combinational side too, so no write or grant leaks out in the reset cycle.
  assign in_rst  = (rst == RST_ENABLE);
  assign run_en  = !in_rst && (state_q == RC_RUN);
  assign load_en = !in_rst && (state_q == RC_LOAD);

  assign d_ok   = addr_in_range(d_addr_i, ROM_WORDS);
  assign i_ok   = addr_in_range(i_addr_i, ROM_WORDS);
  assign ld_ok  = addr_in_range(ld_addr_i, ROM_WORDS);
  assign wr_ok  = load_en && ld_req_i && ld_ok;
  assign wr_bad = load_en && ld_req_i && !ld_ok;

  rom_rd_arb u_rd_arb (
    .en_i     (run_en),
    .d_req_i  (d_req_i),
    .i_req_i  (i_req_i),
    .starve_i (starve_q),
    .d_gnt_o  (d_gnt),
    .i_gnt_o  (i_gnt),
    .hold_o   (arb_hold)
  );

  // ROM port: loader writes and granted reads are mutually exclusive by FSM state.
  always_comb begin
    rom_we_o   = 1'b0;
    rom_addr_o = ZERO_WORD;
    rom_data_o = ZERO_WORD;
    if (wr_ok) begin
      rom_we_o   = WRITE_ENABLE;
      rom_addr_o = word_align(ld_addr_i);
      rom_data_o = ld_data_i;
    end else if (d_gnt && d_ok) begin
      rom_addr_o = word_align(d_addr_i);
    end else if (i_gnt && i_ok) begin
      rom_addr_o = word_align(i_addr_i);
    end
  end

  always_comb begin
    state_d    = state_q;
    rel_cnt_d  = rel_cnt_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      RC_RUN: begin
        if (ld_start_i) begin
          state_d    = RC_LOAD;
          word_cnt_d = 16'h0000;
        end
      end
      RC_LOAD: begin
        if (wr_ok && word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'h0001;
        if (ld_start_i) begin
          word_cnt_d = 16'h0000;
        end else if (ld_done_i) begin
          state_d   = RC_REL;
          rel_cnt_d = 8'(REL_CYCLES - 1);
        end
      end
      RC_REL: begin
        if (ld_start_i) begin
          state_d    = RC_LOAD;
          word_cnt_d = 16'h0000;
        end else if (rel_cnt_q == 8'd0) begin
          state_d = RC_RUN;
        end else begin
          rel_cnt_d = rel_cnt_q - 8'd1;
        end
      end
      default: state_d = RC_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (in_rst) begin
      state_q    <= RC_RUN;
      rel_cnt_q  <= 8'd0;
      word_cnt_q <= 16'h0000;
      starve_q   <= 1'b0;
      d_valid_q  <= 1'b0;
      i_valid_q  <= 1'b0;
      d_rdata_q  <= ZERO_WORD;
      i_rdata_q  <= ZERO_WORD;
      ld_ack_q   <= 1'b0;
      ld_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rel_cnt_q  <= rel_cnt_d;
      word_cnt_q <= word_cnt_d;
      starve_q   <= run_en && i_req_i && !i_gnt;
      d_valid_q  <= d_gnt;
      i_valid_q  <= i_gnt;
      ld_ack_q   <= wr_ok;
      ld_err_q   <= wr_bad;
      if (d_gnt) d_rdata_q <= d_ok ? rom_data_i : ZERO_WORD;
      if (i_gnt) i_rdata_q <= i_ok ? rom_data_i : ZERO_WORD;
    end
  end

  assign hold_o     = !in_rst && ((state_q != RC_RUN) || arb_hold);
  assign cpu_rst_o  = !in_rst && (state_q == RC_REL);
  assign word_cnt_o = word_cnt_q;
  assign d_valid_o  = d_valid_q;
  assign i_valid_o  = i_valid_q;
  assign d_rdata_o  = d_rdata_q;
  assign i_rdata_o  = i_rdata_q;
  assign ld_ack_o   = ld_ack_q;
  assign ld_err_o   = ld_err_q;

endmodule

// File: tb/tb_rom_ctrl.sv
// Directed + randomized bench for rom_ctrl with a behavioural ROM and an expected-contents model.
module tb_rom_ctrl;

  localparam int unsigned ROM_WORDS = rom_ctrl_pkg::ROM_NUM;
  localparam int unsigned REL       = 8;
  localparam int          AW        = $clog2(ROM_WORDS);

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start_i, ld_done_i, ld_req_i;
  logic [31:0] ld_addr_i, ld_data_i;
  logic        ld_ack_o, ld_err_o;
  logic        d_req_i, i_req_i;
  logic [31:0] d_addr_i, i_addr_i;
  logic        d_valid_o, i_valid_o;
  logic [31:0] d_rdata_o, i_rdata_o;
  logic        rom_we_o;
  logic [31:0] rom_addr_o, rom_data_o, rom_data_i;
  logic        hold_o, cpu_rst_o;
  logic [15:0] word_cnt_o;

  logic [31:0] rom     [ROM_WORDS];
  logic [31:0] exp_mem [ROM_WORDS];
  logic        preload;
  int          total = 0;
  int          bad   = 0;

  rom_ctrl #(.ROM_WORDS(ROM_WORDS), .REL_CYCLES(REL)) dut (
    .clk(clk), .rst(rst),
    .ld_start_i(ld_start_i), .ld_done_i(ld_done_i), .ld_req_i(ld_req_i),
    .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i), .ld_ack_o(ld_ack_o), .ld_err_o(ld_err_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_valid_o(d_valid_o), .d_rdata_o(d_rdata_o),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_valid_o(i_valid_o), .i_rdata_o(i_rdata_o),
    .rom_we_o(rom_we_o), .rom_addr_o(rom_addr_o), .rom_data_o(rom_data_o), .rom_data_i(rom_data_i),
    .hold_o(hold_o), .cpu_rst_o(cpu_rst_o), .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  // Behavioural single-port ROM: combinational read, synchronous write.
  assign rom_data_i = rom[rom_addr_o[AW+1:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < int'(ROM_WORDS); i++) rom[i] <= exp_mem[i];
    end else if (rom_we_o) begin
      rom[rom_addr_o[AW+1:2]] <= rom_data_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a / 4) < ROM_WORDS;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    return in_range(a) ? exp_mem[a[AW+1:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'(ROM_WORDS * 4 + $urandom_range(0, 255));
    return 32'($urandom_range(0, ROM_WORDS * 4 - 1));
  endfunction

  // Random contention traffic; the model applies the arbitration rules cycle by cycle.
  task automatic rand_reads(input int n);
    logic        exp_dv = 1'b0, exp_iv = 1'b0;
    logic [31:0] exp_dd = 32'h0, exp_id = 32'h0, ea, da, ia;
    bit          denied = 1'b0, dr, ir, fw, dw;
    for (int k = 0; k < n; k++) begin
      dr = ($urandom_range(0, 9) < 6);
      ir = ($urandom_range(0, 9) < 6);
      da = rand_addr();
      ia = rand_addr();
      d_req_i = dr; d_addr_i = da; i_req_i = ir; i_addr_i = ia;
      #1;
      chk("rr_dvalid", 32'(d_valid_o), 32'(exp_dv));
      if (exp_dv) chk("rr_drdata", d_rdata_o, exp_dd);
      chk("rr_ivalid", 32'(i_valid_o), 32'(exp_iv));
      if (exp_iv) chk("rr_irdata", i_rdata_o, exp_id);
      fw = ir && (!dr || denied);
      dw = dr && !fw;
      chk("rr_hold", 32'(hold_o), 32'(dr && ir));
      ea = 32'h0;
      if (dw && in_range(da)) ea = da & 32'hFFFF_FFFC;
      else if (fw && in_range(ia)) ea = ia & 32'hFFFF_FFFC;
      chk("rr_romaddr", rom_addr_o, ea);
      exp_dv = dw; exp_dd = exp_read(da);
      exp_iv = fw; exp_id = exp_read(ia);
      denied = ir && !fw;
      tick();
    end
    d_req_i = 1'b0; i_req_i = 1'b0;
    #1;
    chk("rr_dvalid_end", 32'(d_valid_o), 32'(exp_dv));
    if (exp_dv) chk("rr_drdata_end", d_rdata_o, exp_dd);
    chk("rr_ivalid_end", 32'(i_valid_o), 32'(exp_iv));
    if (exp_iv) chk("rr_irdata_end", i_rdata_o, exp_id);
    tick();
  endtask

  // Random loader burst inside LOAD, ending with a write in the same cycle as ld_done.
  task automatic rand_loads(input int n);
    int          cnt = 0;
    logic        exp_ack = 1'b0, exp_err = 1'b0;
    logic [31:0] a, w;
    bit          req, ok, last;
    for (int k = 0; k < n; k++) begin
      last = (k == n - 1);
      req  = last ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (last) a = 32'($urandom_range(0, ROM_WORDS * 4 - 1));
      else a = rand_addr();
      w = $urandom;
      ld_req_i = req; ld_addr_i = a; ld_data_i = w; ld_done_i = last;
      #1;
      ok = req && in_range(a);
      chk("rl_we", 32'(rom_we_o), 32'(ok));
      if (ok) begin
        chk("rl_addr", rom_addr_o, a & 32'hFFFF_FFFC);
        chk("rl_data", rom_data_o, w);
      end
      chk("rl_ack", 32'(ld_ack_o), 32'(exp_ack));
      chk("rl_err", 32'(ld_err_o), 32'(exp_err));
      chk("rl_cnt", 32'(word_cnt_o), 32'(cnt));
      chk("rl_hold", 32'(hold_o), 32'h1);
      exp_ack = ok;
      exp_err = req && !ok;
      if (ok) begin
        cnt++;
        exp_mem[a[AW+1:2]] = w;
      end
      tick();
    end
    ld_req_i = 1'b0; ld_done_i = 1'b0;
    #1;
    chk("rl_ack_end", 32'(ld_ack_o), 32'(exp_ack));
    chk("rl_err_end", 32'(ld_err_o), 32'(exp_err));
    chk("rl_cnt_end", 32'(word_cnt_o), 32'(cnt));
  endtask

  // Counts cycles with the core held in reset; bounded so a stuck FSM cannot hang the run.
  task automatic wait_release(input string tag);
    int n = 0;
    for (int k = 0; k < int'(REL) + 4; k++) begin
      if (cpu_rst_o === 1'b1 && hold_o === 1'b1) n++;
      tick();
    end
    chk(tag, 32'(n), 32'(REL));
    chk({tag, "_end"}, 32'(cpu_rst_o), 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; preload = 1'b1;
    ld_start_i = 1'b0; ld_done_i = 1'b0; ld_req_i = 1'b0;
    ld_addr_i = 32'h0; ld_data_i = 32'h0;
    d_req_i = 1'b1; i_req_i = 1'b1; d_addr_i = 32'h0; i_addr_i = 32'h0;
    for (int i = 0; i < int'(ROM_WORDS); i++) exp_mem[i] = $urandom;
    exp_mem[2] = 32'hDEAD_BEEF;

    // Reset, with requests pending
    tick(); tick();
    chk("rst_hold", 32'(hold_o), 32'h0);
    chk("rst_romaddr", rom_addr_o, 32'h0);
    preload = 1'b0; rst = 1'b0; d_req_i = 1'b0; i_req_i = 1'b0;
    #1;
    chk("rst_dvalid", 32'(d_valid_o), 32'h0);
    chk("rst_ivalid", 32'(i_valid_o), 32'h0);
    chk("rst_drdata", d_rdata_o, 32'h0);
    chk("rst_irdata", i_rdata_o, 32'h0);
    chk("rst_cnt", 32'(word_cnt_o), 32'h0);
    chk("rst_cpurst", 32'(cpu_rst_o), 32'h0);
    chk("rst_we", 32'(rom_we_o), 32'h0);
    chk("rst_romdata", rom_data_o, 32'h0);
    chk("rst_ack", 32'(ld_ack_o), 32'h0);
    chk("rst_err", 32'(ld_err_o), 32'h0);
    tick();

    // Fetch only
    i_req_i = 1'b1; i_addr_i = 32'h8;
    #1;
    chk("f_romaddr", rom_addr_o, 32'h8);
    chk("f_hold", 32'(hold_o), 32'h0);
    tick();
    i_req_i = 1'b0;
    #1;
    chk("f_ivalid", 32'(i_valid_o), 32'h1);
    chk("f_irdata", i_rdata_o, 32'hDEAD_BEEF);
    chk("f_dvalid", 32'(d_valid_o), 32'h0);
    tick();
    chk("f_ivalid_once", 32'(i_valid_o), 32'h0);

    // Loader write in RUN is ignored
    ld_req_i = 1'b1; ld_addr_i = 32'h0; ld_data_i = 32'hFFFF_FFFF;
    #1;
    chk("run_ld_we", 32'(rom_we_o), 32'h0);
    tick();
    ld_req_i = 1'b0;
    #1;
    chk("run_ld_ack", 32'(ld_ack_o), 32'h0);
    chk("run_ld_err", 32'(ld_err_o), 32'h0);
    tick();

    // Both requesting for 3 cycles: data, fetch, data
    d_req_i = 1'b1; i_req_i = 1'b1; d_addr_i = 32'h10; i_addr_i = 32'h14;
    #1;
    chk("c1_hold", 32'(hold_o), 32'h1);
    chk("c1_romaddr", rom_addr_o, 32'h10);
    tick();
    chk("c2_hold", 32'(hold_o), 32'h1);
    chk("c2_romaddr", rom_addr_o, 32'h14);
    chk("c2_dvalid", 32'(d_valid_o), 32'h1);
    chk("c2_drdata", d_rdata_o, exp_mem[4]);
    chk("c2_ivalid", 32'(i_valid_o), 32'h0);
    tick();
    chk("c3_hold", 32'(hold_o), 32'h1);
    chk("c3_romaddr", rom_addr_o, 32'h10);
    chk("c3_ivalid", 32'(i_valid_o), 32'h1);
    chk("c3_irdata", i_rdata_o, exp_mem[5]);
    chk("c3_dvalid", 32'(d_valid_o), 32'h0);
    tick();
    d_req_i = 1'b0; i_req_i = 1'b0;
    #1;
    chk("c4_dvalid", 32'(d_valid_o), 32'h1);
    chk("c4_ivalid", 32'(i_valid_o), 32'h0);
    tick();

    rand_reads(150);

    // Directed load session
    ld_start_i = 1'b1;
    tick();
    ld_start_i = 1'b0; ld_req_i = 1'b1; ld_addr_i = 32'h0; ld_data_i = 32'h11;
    #1;
    chk("ld_hold", 32'(hold_o), 32'h1);
    chk("ld_cnt0", 32'(word_cnt_o), 32'h0);
    chk("ld_we0", 32'(rom_we_o), 32'h1);
    chk("ld_addr0", rom_addr_o, 32'h0);
    chk("ld_data0", rom_data_o, 32'h11);
    tick();
    ld_addr_i = 32'h4; ld_data_i = 32'h22;
    #1;
    chk("ld_ack0", 32'(ld_ack_o), 32'h1);
    chk("ld_addr1", rom_addr_o, 32'h4);
    tick();
    ld_addr_i = 32'h8; ld_data_i = 32'h33;
    #1;
    chk("ld_ack1", 32'(ld_ack_o), 32'h1);
    chk("ld_cnt2", 32'(word_cnt_o), 32'h2);
    tick();
    ld_req_i = 1'b0; ld_done_i = 1'b1;
    #1;
    chk("ld_ack2", 32'(ld_ack_o), 32'h1);
    chk("ld_cnt3", 32'(word_cnt_o), 32'h3);
    tick();
    ld_done_i = 1'b0;
    exp_mem[0] = 32'h11; exp_mem[1] = 32'h22; exp_mem[2] = 32'h33;
    wait_release("rel_len");
    chk("rel_cnt_kept", 32'(word_cnt_o), 32'h3);
    d_req_i = 1'b1; d_addr_i = 32'h4;
    tick();
    d_req_i = 1'b0;
    #1;
    chk("rb_dvalid", 32'(d_valid_o), 32'h1);
    chk("rb_drdata", d_rdata_o, 32'h22);
    tick();

    // Out-of-range write
    ld_start_i = 1'b1;
    tick();
    w = $urandom;
    ld_start_i = 1'b0; ld_req_i = 1'b1; ld_addr_i = 32'h20; ld_data_i = w;
    #1;
    chk("oor_pre_we", 32'(rom_we_o), 32'h1);
    tick();
    exp_mem[8] = w;
    ld_addr_i = 32'(ROM_WORDS * 4);
    #1;
    chk("oor_we", 32'(rom_we_o), 32'h0);
    chk("oor_pre_ack", 32'(ld_ack_o), 32'h1);
    tick();
    ld_req_i = 1'b0;
    #1;
    chk("oor_err", 32'(ld_err_o), 32'h1);
    chk("oor_ack", 32'(ld_ack_o), 32'h0);
    chk("oor_cnt", 32'(word_cnt_o), 32'h1);
    tick();

    // Start and done together: start wins
    ld_start_i = 1'b1; ld_done_i = 1'b1;
    tick();
    ld_start_i = 1'b0; ld_done_i = 1'b0;
    #1;
    chk("sd_hold", 32'(hold_o), 32'h1);
    chk("sd_cpurst", 32'(cpu_rst_o), 32'h0);
    chk("sd_cnt", 32'(word_cnt_o), 32'h0);
    ld_done_i = 1'b1;
    tick();
    ld_done_i = 1'b0;
    #1;
    chk("ab_rel1", 32'(cpu_rst_o), 32'h1);
    tick(); tick();
    ld_start_i = 1'b1;
    #1;
    chk("ab_rel3", 32'(cpu_rst_o), 32'h1);
    tick();
    ld_start_i = 1'b0;
    #1;
    chk("ab_cpurst", 32'(cpu_rst_o), 32'h0);
    chk("ab_hold", 32'(hold_o), 32'h1);
    chk("ab_cnt", 32'(word_cnt_o), 32'h0);

    rand_loads(40);
    wait_release("rel_len2");
    rand_reads(150);

    // Out-of-range read
    d_req_i = 1'b1; d_addr_i = 32'(ROM_WORDS * 4);
    #1;
    chk("oorr_romaddr", rom_addr_o, 32'h0);
    tick();
    d_req_i = 1'b0;
    #1;
    chk("oorr_dvalid", 32'(d_valid_o), 32'h1);
    chk("oorr_drdata", d_rdata_o, 32'h0);
    tick();

    // Reset in the middle of LOAD with a write pending
    ld_start_i = 1'b1;
    tick();
    ld_start_i = 1'b0; ld_req_i = 1'b1; ld_addr_i = 32'hC; ld_data_i = ~exp_mem[3]; rst = 1'b1;
    #1;
    chk("mr_we", 32'(rom_we_o), 32'h0);
    tick();
    rst = 1'b0; ld_req_i = 1'b0;
    #1;
    chk("mr_hold", 32'(hold_o), 32'h0);
    chk("mr_cpurst", 32'(cpu_rst_o), 32'h0);
    chk("mr_cnt", 32'(word_cnt_o), 32'h0);
    chk("mr_ack", 32'(ld_ack_o), 32'h0);
    chk("mr_we_after", 32'(rom_we_o), 32'h0);
    d_req_i = 1'b1; d_addr_i = 32'hC;
    tick();
    d_req_i = 1'b0;
    #1;
    chk("mr_dvalid", 32'(d_valid_o), 32'h1);
    chk("mr_drdata", d_rdata_o, exp_mem[3]);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
